rob_ctrl: RTL

//  Sequencing controller for the banked reorder buffer. Allocates one ROB row (NBANK slots) per

---
 rtl/rob_ctrl_if.sv | 38 +++
 rtl/rob_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/rob_ctrl_if.sv
// Dispatch, writeback and commit signal bundle for the banked reorder-buffer controller.
// master drives requests/writebacks; slave is the controller.
interface rob_ctrl_if #(
  parameter int NBANK = 4,
  parameter int ROWS  = 16,
  parameter int NWB   = 2
);
  localparam int ROW_W = $clog2(ROWS);
  localparam int TAG_W = ROW_W + $clog2(NBANK);

  logic                   i_dis_valid;
  logic [NBANK-1:0]       i_dis_mask;
  logic                   o_dis_ready;
  logic [ROW_W-1:0]       o_dis_row;
  logic [NWB-1:0]         i_wb_valid;
  logic [NWB*TAG_W-1:0]   i_wb_tag;
  logic [NWB-1:0]         i_wb_exc;
  logic                   o_commit_valid;
  logic [ROW_W-1:0]       o_commit_row;
  logic [NBANK-1:0]       o_commit_mask;
  logic                   o_flush;
  logic [TAG_W-1:0]       o_exc_tag;
  logic [ROW_W:0]         o_count;
  logic                   o_empty;
  logic                   o_full;

  modport master (
    output i_dis_valid, i_dis_mask, i_wb_valid, i_wb_tag, i_wb_exc,
    input  o_dis_ready, o_dis_row, o_commit_valid, o_commit_row, o_commit_mask,
           o_flush, o_exc_tag, o_count, o_empty, o_full
  );

  modport slave (
    input  i_dis_valid, i_dis_mask, i_wb_valid, i_wb_tag, i_wb_exc,
    output o_dis_ready, o_dis_row, o_commit_valid, o_commit_row, o_commit_mask,
           o_flush, o_exc_tag, o_count, o_empty, o_full
  );
endinterface

// File: rtl/rob_ctrl.sv
// Banked ROB sequencer: allocates one row per dispatch, tracks val/busy/exc per slot, retires head in order.
// Commit/flush are combinational from registered state; dispatch stalls while full or flushing.
module rob_ctrl #(
  parameter int NBANK = 4,
  parameter int ROWS  = 16,
  parameter int NWB   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  rob_ctrl_if.slave  bus
);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int SLOT_W = $clog2(NBANK);
  localparam int TAG_W  = ROW_W + SLOT_W;
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;
  localparam logic [ROW_W:0]   FULL_CNT = ROWS[ROW_W:0];
  localparam logic [ROW_W:0]   CNT_ONE  = {{ROW_W{1'b0}}, 1'b1};
  localparam logic [ROW_W-1:0] PTR_ONE  = {{(ROW_W-1){1'b0}}, 1'b1};

  logic [NBANK-1:0] r_val  [ROWS];
  logic [NBANK-1:0] r_busy [ROWS];
  logic [NBANK-1:0] r_exc  [ROWS];
  logic [ROW_W-1:0] r_head, r_tail;
  logic [ROW_W:0]   r_count;
  logic [0:0]       r_state;

  logic              w_run, w_full, w_empty, w_ready, w_accept;
  logic [NBANK-1:0]  w_hval, w_hbusy, w_hexc, w_le, w_lt, w_gate;
  logic [SLOT_W-1:0] w_e;
  logic              w_has_e, w_fire, w_flush, w_commit_norm;
  logic [ROW_W-1:0]  w_wb_row  [NWB];
  logic [SLOT_W-1:0] w_wb_slot [NWB];
  logic [NWB-1:0]    w_wb_ok;

  assign w_run   = (r_state == ST_RUN);
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_ready = w_run & ~w_full;
  assign w_hval  = r_val[r_head];
  assign w_hbusy = r_busy[r_head];
  assign w_hexc  = r_exc[r_head];

  // w_le covers slots 0..e, w_lt slots strictly below e (all ones when no exception)
  always_comb begin
    w_e     = '0;
    w_has_e = 1'b0;
    w_le    = '0;
    w_lt    = '0;
    for (int i = 0; i < NBANK; i++) begin
      w_le[i] = ~w_has_e;
      if (!w_has_e && w_hval[i] && w_hexc[i]) begin
        w_e     = SLOT_W'(i);
        w_has_e = 1'b1;
      end
      w_lt[i] = ~w_has_e;
    end
  end

  assign w_gate        = w_has_e ? w_le : {NBANK{1'b1}};
  assign w_fire        = w_run & ~w_empty & ~|(w_hval & w_hbusy & w_gate);
  assign w_flush       = w_fire & w_has_e;
  assign w_commit_norm = w_fire & ~w_has_e;
  assign w_accept      = bus.i_dis_valid & w_ready & (|bus.i_dis_mask) & ~w_flush;

  // A writeback to the row retiring this cycle is dropped along with the row
  always_comb begin
    for (int k = 0; k < NWB; k++) begin
      w_wb_row[k]  = bus.i_wb_tag[k*TAG_W+SLOT_W +: ROW_W];
      w_wb_slot[k] = bus.i_wb_tag[k*TAG_W +: SLOT_W];
      w_wb_ok[k]   = bus.i_wb_valid[k] & w_run & ~w_flush
                   & r_val[w_wb_row[k]][w_wb_slot[k]]
                   & ~(w_commit_norm & (w_wb_row[k] == r_head));
    end
  end

  assign bus.o_dis_ready    = w_ready;
  assign bus.o_dis_row      = r_tail;
  assign bus.o_commit_valid = w_fire;
  assign bus.o_commit_row   = r_head;
  assign bus.o_commit_mask  = w_fire ? (w_hval & w_lt) : '0;
  assign bus.o_flush        = w_flush;
  assign bus.o_exc_tag      = w_flush ? {r_head, w_e} : '0;
  assign bus.o_count        = r_count;
  assign bus.o_empty        = w_empty;
  assign bus.o_full         = w_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < ROWS; r++) begin
        r_val[r]  <= '0;
        r_busy[r] <= '0;
        r_exc[r]  <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= ST_RUN;
    end else if (w_flush) begin
      for (int r = 0; r < ROWS; r++) begin
        r_val[r]  <= '0;
        r_busy[r] <= '0;
        r_exc[r]  <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= ST_FLUSH;
    end else begin
      r_state <= ST_RUN;
      for (int k = 0; k < NWB; k++) begin
        if (w_wb_ok[k]) begin
          r_busy[w_wb_row[k]][w_wb_slot[k]] <= 1'b0;
          if (bus.i_wb_exc[k]) r_exc[w_wb_row[k]][w_wb_slot[k]] <= 1'b1;
        end
      end
      if (w_commit_norm) begin
        r_val[r_head] <= '0;
        r_head        <= r_head + PTR_ONE;
      end
      if (w_accept) begin
        r_val[r_tail]  <= bus.i_dis_mask;
        r_busy[r_tail] <= bus.i_dis_mask;
        r_exc[r_tail]  <= '0;
        r_tail         <= r_tail + PTR_ONE;
      end
      if (w_accept && !w_commit_norm) r_count <= r_count + CNT_ONE;
      else if (!w_accept && w_commit_norm) r_count <= r_count - CNT_ONE;
    end
  end
endmodule
